// File: rtl/alu_vec_driver_pkg.sv
// Shared types, default widths and the masked-compare helper for the
// ALU vector driver.
package alu_drv_pkg;

  localparam int PI_W_DEF = 10;
  localparam int PO_W_DEF = 6;
  // Widest output bus the compare helper handles; callers zero-extend.
  localparam int PO_W_MAX = 64;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    RESP   = 2'd2
  } state_e;

  // True when any bit selected by mask differs between po and expv.
  function automatic logic masked_mismatch(input logic [PO_W_MAX-1:0] po,
                                           input logic [PO_W_MAX-1:0] expv,
                                           input logic [PO_W_MAX-1:0] mask);
    return |((po ^ expv) & mask);
  endfunction

endpackage

// File: rtl/alu_vec_driver_if.sv
// Vector-in / result-out streams plus the ALU pin buses.
// master = the driver, slave = the harness that feeds it and hosts the ALU.
interface alu_vec_driver_if #(
  parameter int PI_W = 10,
  parameter int PO_W = 6
) ();

  logic            in_valid;
  logic            in_ready;
  logic [PI_W-1:0] in_pi;
  logic [PO_W-1:0] in_exp;
  logic [PO_W-1:0] in_mask;

  logic [PI_W-1:0] dut_pi;
  logic [PO_W-1:0] dut_po;

  logic            out_valid;
  logic            out_ready;
  logic [PO_W-1:0] out_po;
  logic            out_err;

  modport master (
    input  in_valid, in_pi, in_exp, in_mask, dut_po, out_ready,
    output in_ready, dut_pi, out_valid, out_po, out_err
  );

  modport slave (
    output in_valid, in_pi, in_exp, in_mask, dut_po, out_ready,
    input  in_ready, dut_pi, out_valid, out_po, out_err
  );

endinterface

// File: rtl/alu_vec_driver_sat_counter.sv
// Saturating up-counter with synchronous clear.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  // Count up on inc, stick at all-ones, clear/reset to zero.
  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous here, so it sits inside the clocked branch
    // and is only seen on a rising edge; state updates use non-blocking (<=)
    // so every flop samples pre-edge values regardless of block ordering.
    if (!rst_n) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc && (q != {W{1'b1}})) begin
      q <= q + W'(1);
    end
  end

endmodule

// File: rtl/alu_vec_driver.sv
// Applies one vector at a time to the ALU, waits SETTLE_CYC cycles,
// captures and mask-compares the outputs, and reports the result.
module alu_vec_driver
  import alu_drv_pkg::*;
#(
  parameter int PI_W       = PI_W_DEF,
  parameter int PO_W       = PO_W_DEF,
  parameter int SETTLE_CYC = 2,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  alu_vec_driver_if.master bus,
  input  logic             clear,
  output logic [CNT_W-1:0] vec_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  // Counter only ever holds SETTLE_CYC-1 down to 0.
  localparam int CW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

  state_e          state;
  logic [CW-1:0]   settle_cnt;
  logic [PI_W-1:0] dut_pi_q;
  logic [PO_W-1:0] exp_q;
  logic [PO_W-1:0] mask_q;
  logic [PO_W-1:0] out_po_q;
  logic            out_err_q;
  logic            in_ready_q;
  logic            out_valid_q;
  logic            resp_done;

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.dut_pi    = dut_pi_q;
  assign bus.out_po    = out_po_q;
  assign bus.out_err   = out_err_q;

  assign resp_done = (state == RESP) && bus.out_ready;

  // Accept -> settle -> capture -> respond sequencer with registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      settle_cnt  <= '0;
      dut_pi_q    <= '0;
      exp_q       <= '0;
      mask_q      <= '0;
      out_po_q    <= '0;
      out_err_q   <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.in_valid) begin
            dut_pi_q   <= bus.in_pi;
            exp_q      <= bus.in_exp;
            mask_q     <= bus.in_mask;
            settle_cnt <= CW'(SETTLE_CYC - 1);
            in_ready_q <= 1'b0;
            state      <= SETTLE;
          end
        end
        SETTLE: begin
          if (settle_cnt != '0) begin
            settle_cnt <= settle_cnt - CW'(1);
          end else begin
            out_po_q    <= bus.dut_po;
            out_err_q   <= masked_mismatch(PO_W_MAX'(bus.dut_po),
                                           PO_W_MAX'(exp_q),
                                           PO_W_MAX'(mask_q));
            out_valid_q <= 1'b1;
            state       <= RESP;
          end
        end
        RESP: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state       <= IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state       <= IDLE;
        end
      endcase
    end
  end

  sat_counter #(.W(CNT_W)) u_vec_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clear),
    .inc   (resp_done),
    .q     (vec_cnt)
  );

  sat_counter #(.W(CNT_W)) u_err_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clear),
    .inc   (resp_done & out_err_q),
    .q     (err_cnt)
  );

endmodule

// File: tb/tb_alu_vec_driver.sv
// Scenario bench for alu_vec_driver (SETTLE_CYC = 2, CNT_W = 2) with a
// behavioural ALU and a scoreboard of expected results.
module tb_alu_vec_driver;
  import alu_drv_pkg::*;

  localparam int PI_W  = 10;
  localparam int PO_W  = 6;
  localparam int CNT_W = 2;

  typedef struct {
    logic [PO_W-1:0] po;
    logic            err;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             clear;
  logic [CNT_W-1:0] vec_cnt;
  logic [CNT_W-1:0] err_cnt;

  logic             alu_fixed;
  logic [PO_W-1:0]  alu_const;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  alu_vec_driver_if #(.PI_W(PI_W), .PO_W(PO_W)) bus ();

  alu_vec_driver #(
    .PI_W(PI_W), .PO_W(PO_W), .SETTLE_CYC(2), .CNT_W(CNT_W)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .clear   (clear),
    .vec_cnt (vec_cnt),
    .err_cnt (err_cnt)
  );

  always #5 clk = ~clk;

  // Behavioural ALU: either a fixed output or a scrambling function of dut_pi.
  function automatic logic [PO_W-1:0] alu_fn(input logic [PI_W-1:0] pi);
    logic [PO_W-1:0] k;
    k = 6'h2B;
    return pi[5:0] ^ pi[9:4] ^ k;
  endfunction

  function automatic logic [PO_W-1:0] model_po(input logic [PI_W-1:0] pi);
    return alu_fixed ? alu_const : alu_fn(pi);
  endfunction

  assign bus.dut_po = model_po(bus.dut_pi);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a vector and wait (bounded) for the accept edge; returns 1ns after it.
  task automatic accept_vec(input logic [PI_W-1:0] pi, input logic [PO_W-1:0] ex,
                            input logic [PO_W-1:0] mk);
    bit ok;
    ok = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_pi    = pi;
    bus.in_exp   = ex;
    bus.in_mask  = mk;
    for (int k = 0; k < 20; k++) begin
      if (bus.in_ready) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL accept_timeout in_ready=%0b required=1", bus.in_ready);
    end
    tick();
    bus.in_valid = 1'b0;
  endtask

  // Queue the expected result for a vector, computed from the ALU model.
  task automatic push_exp(input logic [PI_W-1:0] pi, input logic [PO_W-1:0] ex,
                          input logic [PO_W-1:0] mk);
    exp_t e;
    e.po  = model_po(pi);
    e.err = |((e.po ^ ex) & mk);
    sb.push_back(e);
  endtask

  // Wait (bounded) for out_valid, then pop and compare against the scoreboard.
  task automatic wait_and_check(input string tag);
    bit   ok;
    exp_t e;
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (bus.out_valid) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s out_valid_timeout out_valid=%0b required=1", tag, bus.out_valid);
      return;
    end
    total++;
    if (sb.size() == 0) begin
      bad++;
      $display("FAIL %s unexpected_result out_po=%h", tag, bus.out_po);
      return;
    end
    e = sb.pop_front();
    if (bus.out_po !== e.po) begin
      bad++;
      $display("FAIL %s out_po got=%h exp=%h", tag, bus.out_po, e.po);
    end
    total++;
    if (bus.out_err !== e.err) begin
      bad++;
      $display("FAIL %s out_err got=%0b exp=%0b", tag, bus.out_err, e.err);
    end
  endtask

  // Full transaction with out_ready high; returns 1ns after the response edge.
  task automatic run_vec(input logic [PI_W-1:0] pi, input logic [PO_W-1:0] ex,
                         input logic [PO_W-1:0] mk, input string tag);
    push_exp(pi, ex, mk);
    accept_vec(pi, ex, mk);
    wait_and_check(tag);
    tick();
  endtask

  task automatic clear_counters();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    total++;
    if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%0b exp=1", bus.in_ready); end
    total++;
    if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%0b exp=0", bus.out_valid); end
    total++;
    if (bus.dut_pi !== '0) begin bad++; $display("FAIL reset_dut_pi got=%h exp=0", bus.dut_pi); end
    total++;
    if (bus.out_po !== '0 || bus.out_err !== 1'b0) begin
      bad++; $display("FAIL reset_out_po got=%h/%0b exp=0/0", bus.out_po, bus.out_err);
    end
    total++;
    if (vec_cnt !== '0 || err_cnt !== '0) begin
      bad++; $display("FAIL reset_counters got=%0d/%0d exp=0/0", vec_cnt, err_cnt);
    end
  endtask

  task automatic test_single();
    alu_fixed = 1'b1;
    alu_const = 6'h15;
    push_exp(10'h2A5, 6'h15, 6'h3F);
    accept_vec(10'h2A5, 6'h15, 6'h3F);
    total++;
    if (bus.dut_pi !== 10'h2A5) begin bad++; $display("FAIL single_dut_pi got=%h exp=2a5", bus.dut_pi); end
    total++;
    if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL single_early_valid_t1 got=%0b exp=0", bus.out_valid); end
    tick();
    total++;
    if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL single_early_valid_t2 got=%0b exp=0", bus.out_valid); end
    tick();
    total++;
    if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL single_latency out_valid got=%0b exp=1", bus.out_valid); end
    wait_and_check("single");
    tick();
    total++;
    if (vec_cnt !== 2'd1 || err_cnt !== 2'd0) begin
      bad++; $display("FAIL single_counters got=%0d/%0d exp=1/0", vec_cnt, err_cnt);
    end
    total++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      bad++; $display("FAIL single_idle in_ready/out_valid got=%0b/%0b exp=1/0", bus.in_ready, bus.out_valid);
    end
  endtask

  task automatic test_masked();
    clear_counters();
    alu_fixed = 1'b1;
    alu_const = 6'h15;
    run_vec(10'h111, 6'h14, 6'h3E, "mask_3e");
    run_vec(10'h222, 6'h14, 6'h01, "mask_01");
    run_vec(10'h333, 6'h00, 6'h00, "mask_00");
    total++;
    if (vec_cnt !== 2'd3 || err_cnt !== 2'd1) begin
      bad++; $display("FAIL masked_counters got=%0d/%0d exp=3/1", vec_cnt, err_cnt);
    end
  endtask

  task automatic test_alu_patterns();
    logic [PI_W-1:0] pi;
    logic [PO_W-1:0] ex;
    logic [PO_W-1:0] mk;
    alu_fixed = 1'b0;
    for (int i = 0; i < 6; i++) begin
      pi = PI_W'($urandom_range(0, 1023));
      mk = PO_W'($urandom_range(0, 63));
      ex = (i % 2 == 0) ? alu_fn(pi) : PO_W'($urandom_range(0, 63));
      run_vec(pi, ex, mk, "alu_pattern");
      total++;
      if (bus.dut_pi !== pi) begin bad++; $display("FAIL pattern_dut_pi_hold got=%h exp=%h", bus.dut_pi, pi); end
    end
    alu_fixed = 1'b1;
  endtask

  task automatic test_backpressure();
    clear_counters();
    alu_const = 6'h15;
    bus.out_ready = 1'b0;
    push_exp(10'h0F0, 6'h00, 6'h3F);
    accept_vec(10'h0F0, 6'h00, 6'h3F);
    wait_and_check("bp_result");
    bus.in_valid = 1'b1;
    bus.in_pi    = 10'h3C3;
    bus.in_exp   = 6'h15;
    bus.in_mask  = 6'h3F;
    alu_const    = 6'h2A;
    for (int i = 0; i < 5; i++) begin
      tick();
      total++;
      if (bus.out_valid !== 1'b1 || bus.out_po !== 6'h15 || bus.out_err !== 1'b1) begin
        bad++;
        $display("FAIL bp_hold valid/po/err got=%0b/%h/%0b exp=1/15/1", bus.out_valid, bus.out_po, bus.out_err);
      end
      total++;
      if (bus.in_ready !== 1'b0 || bus.dut_pi !== 10'h0F0) begin
        bad++; $display("FAIL bp_no_accept in_ready/dut_pi got=%0b/%h exp=0/0f0", bus.in_ready, bus.dut_pi);
      end
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    tick();
    total++;
    if (vec_cnt !== 2'd1 || err_cnt !== 2'd1) begin
      bad++; $display("FAIL bp_count_once got=%0d/%0d exp=1/1", vec_cnt, err_cnt);
    end
    total++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.dut_pi !== 10'h0F0) begin
      bad++;
      $display("FAIL bp_release in_ready/out_valid/dut_pi got=%0b/%0b/%h exp=1/0/0f0", bus.in_ready, bus.out_valid, bus.dut_pi);
    end
    alu_const = 6'h15;
  endtask

  task automatic test_back_to_back();
    int acc;
    int ov;
    clear_counters();
    acc = 0;
    ov  = 0;
    bus.in_valid = 1'b1;
    bus.in_pi    = 10'h155;
    bus.in_exp   = 6'h15;
    bus.in_mask  = 6'h3F;
    for (int i = 0; i < 12; i++) begin
      if (bus.in_valid && bus.in_ready) acc++;
      if (bus.out_valid) begin
        ov++;
        total++;
        if (bus.out_po !== 6'h15 || bus.out_err !== 1'b0) begin
          bad++; $display("FAIL b2b_result po/err got=%h/%0b exp=15/0", bus.out_po, bus.out_err);
        end
      end
      tick();
    end
    bus.in_valid = 1'b0;
    total++;
    if (acc != 3 || ov != 3) begin
      bad++; $display("FAIL b2b_throughput accepts/results got=%0d/%0d exp=3/3", acc, ov);
    end
    total++;
    if (vec_cnt !== 2'd3) begin bad++; $display("FAIL b2b_vec_cnt got=%0d exp=3", vec_cnt); end
  endtask

  task automatic test_saturation_clear();
    clear_counters();
    alu_const = 6'h15;
    for (int i = 0; i < 5; i++) begin
      run_vec(PI_W'(i + 1), 6'h00, 6'h3F, "sat_vec");
    end
    total++;
    if (vec_cnt !== 2'd3 || err_cnt !== 2'd3) begin
      bad++; $display("FAIL sat_counters got=%0d/%0d exp=3/3", vec_cnt, err_cnt);
    end
    push_exp(10'h3FF, 6'h00, 6'h3F);
    accept_vec(10'h3FF, 6'h00, 6'h3F);
    wait_and_check("clear_on_resp");
    clear = 1'b1;
    tick();
    clear = 1'b0;
    total++;
    if (vec_cnt !== 2'd0 || err_cnt !== 2'd0) begin
      bad++; $display("FAIL clear_wins got=%0d/%0d exp=0/0", vec_cnt, err_cnt);
    end
    total++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      bad++; $display("FAIL clear_fsm_unaffected out_valid/in_ready got=%0b/%0b exp=0/1", bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic test_reset_mid();
    int ov;
    ov = 0;
    run_vec(10'h0AA, 6'h15, 6'h3F, "pre_reset");
    accept_vec(10'h2C3, 6'h00, 6'h3F);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    total++;
    if (bus.in_ready !== 1'b1 || bus.dut_pi !== '0) begin
      bad++; $display("FAIL midrst_state in_ready/dut_pi got=%0b/%h exp=1/0", bus.in_ready, bus.dut_pi);
    end
    total++;
    if (vec_cnt !== '0 || err_cnt !== '0) begin
      bad++; $display("FAIL midrst_counters got=%0d/%0d exp=0/0", vec_cnt, err_cnt);
    end
    for (int i = 0; i < 5; i++) begin
      if (bus.out_valid) ov++;
      tick();
    end
    total++;
    if (ov != 0) begin bad++; $display("FAIL midrst_no_valid pulses got=%0d exp=0", ov); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout sim_time=%0t limit=200000", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n         = 1'b0;
    clear         = 1'b0;
    alu_fixed     = 1'b1;
    alu_const     = 6'h15;
    bus.in_valid  = 1'b0;
    bus.in_pi     = '0;
    bus.in_exp    = '0;
    bus.in_mask   = '0;
    bus.out_ready = 1'b1;

    test_reset();
    test_single();
    test_masked();
    test_alu_patterns();
    test_backpressure();
    test_back_to_back();
    test_saturation_clear();
    test_reset_mid();

    total++;
    if (sb.size() != 0) begin
      bad++; $display("FAIL scoreboard_drain left=%0d exp=0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
